// File: rtl/router_nport_core.sv
// router_nport_core
//   Single-clock 1xN packet router core. Parses {header, payload..., parity} packets from one
//   byte stream and steers each packet into one of NUM_PORTS output FIFOs. Adds illegal-header
//   drop, truncation detection and a per-port idle-reader timeout that soft-flushes a FIFO.
// Ports
//   clk1             : sole clock, rising edge
//   reset            : asynchronous, active-high, clears all state
//   packet_valid_i   : source presents a byte on packet_in
//   packet_in        : packet byte; header = {len[7:2], dest[1:0]}
//   read_enable      : per-port pop request
//   packet_out       : registered per-port read data, port k = packet_out[8k+7:8k]
//   packet_valid_o   : per-port FIFO non-empty
//   busy             : byte on packet_in is not accepted this cycle
//   stop_packet_send : OR of all FIFO-full flags
//   err              : 1-cycle pulse on parity mismatch, illegal header or truncation
//   flush            : per-port 1-cycle pulse when that FIFO is soft-flushed by the timeout
module router_nport_core #(
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TIMEOUT   = 30
) (
    input  logic                   clk1,
    input  logic                   reset,
    input  logic                   packet_valid_i,
    input  logic [7:0]             packet_in,
    input  logic [NUM_PORTS-1:0]   read_enable,
    output logic [8*NUM_PORTS-1:0] packet_out,
    output logic [NUM_PORTS-1:0]   packet_valid_o,
    output logic                   busy,
    output logic                   stop_packet_send,
    output logic                   err,
    output logic [NUM_PORTS-1:0]   flush
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   PtrOne = (AW + 1)'(1);
    localparam logic [TW-1:0] TmoOne = TW'(1);
    localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDrop} state_e;

    state_e      state_q;
    logic [1:0]  dest_q;
    logic [5:0]  len_q;
    logic [5:0]  cnt_q;
    logic [7:0]  par_q;
    logic [7:0]  par_rx_q;
    logic        err_q;

    logic [AW:0]   wptr_q [NUM_PORTS];
    logic [AW:0]   rptr_q [NUM_PORTS];
    logic [7:0]    mem_q  [NUM_PORTS][DEPTH];
    logic [7:0]    dout_q [NUM_PORTS];
    logic [TW-1:0] tmo_q  [NUM_PORTS];
    logic [NUM_PORTS-1:0] flush_q;

    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic [3:0]           full_ext;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] rd_en;
    logic [1:0]           hdr_dest;
    logic                 dest_legal;
    logic                 hdr_legal;
    logic                 busy_c;
    logic                 accept;

    always_comb begin
        empty    = '0;
        full     = '0;
        full_ext = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            empty[k] = (wptr_q[k] == rptr_q[k]);
            full[k]  = (wptr_q[k][AW] != rptr_q[k][AW]) &&
                       (wptr_q[k][AW-1:0] == rptr_q[k][AW-1:0]);
        end
        // Pad to the full 2-bit dest space so any header value can index it.
        full_ext[NUM_PORTS-1:0] = full;
    end

    assign hdr_dest   = packet_in[1:0];
    assign dest_legal = (32'(hdr_dest) < NUM_PORTS);
    assign hdr_legal  = dest_legal && (packet_in[7:2] != 6'd0);

    // Illegal headers are never stalled: they are dropped, so FIFO state is irrelevant.
    assign busy_c = ((state_q == StIdle) && dest_legal && full_ext[hdr_dest]) ||
                    ((state_q == StLoad) && full_ext[dest_q]) ||
                    (state_q == StCheck);
    assign accept = packet_valid_i && !busy_c;

    always_comb begin
        wr_en = '0;
        rd_en = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            wr_en[k] = accept &&
                       (((state_q == StIdle) && hdr_legal && (hdr_dest == 2'(k))) ||
                        ((state_q == StLoad) && (dest_q == 2'(k))));
            rd_en[k] = read_enable[k] && !empty[k];
        end
    end

    // Packet parser FSM.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            dest_q   <= 2'd0;
            len_q    <= 6'd0;
            cnt_q    <= 6'd0;
            par_q    <= 8'd0;
            par_rx_q <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (hdr_legal) begin
                            dest_q  <= hdr_dest;
                            len_q   <= packet_in[7:2];
                            cnt_q   <= 6'd0;
                            par_q   <= packet_in;
                            state_q <= StLoad;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StDrop;
                        end
                    end
                end
                StLoad: begin
                    if (!packet_valid_i) begin
                        // Truncated packet: bytes already stored are left in the FIFO.
                        err_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (accept) begin
                        if (cnt_q == len_q) begin
                            par_rx_q <= packet_in;
                            state_q  <= StCheck;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                            par_q <= par_q ^ packet_in;
                        end
                    end
                end
                StCheck: begin
                    err_q   <= (par_rx_q != par_q);
                    state_q <= StIdle;
                end
                StDrop: begin
                    if (!packet_valid_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FIFO pointers, read data and idle-reader timeout.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            flush_q <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                dout_q[k] <= 8'd0;
                tmo_q[k]  <= '0;
            end
        end else begin
            flush_q <= '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (wr_en[k]) wptr_q[k] <= wptr_q[k] + PtrOne;
                if (rd_en[k]) begin
                    rptr_q[k] <= rptr_q[k] + PtrOne;
                    dout_q[k] <= mem_q[k][rptr_q[k][AW-1:0]];
                end
                if (empty[k] || read_enable[k]) begin
                    tmo_q[k] <= '0;
                end else if (tmo_q[k] == TmoMax) begin
                    // Soft flush discards stored bytes; a byte written this same edge survives.
                    tmo_q[k]   <= '0;
                    flush_q[k] <= 1'b1;
                    rptr_q[k]  <= wptr_q[k];
                end else begin
                    tmo_q[k] <= tmo_q[k] + TmoOne;
                end
            end
        end
    end

    // Storage array carries no reset; pointers alone define validity.
    always_ff @(posedge clk1) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (wr_en[k]) mem_q[k][wptr_q[k][AW-1:0]] <= packet_in;
        end
    end

    always_comb begin
        packet_out     = '0;
        packet_valid_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            packet_out[8*k +: 8] = dout_q[k];
            packet_valid_o[k]    = !empty[k];
        end
    end

    assign busy             = busy_c;
    assign stop_packet_send = |full;
    assign err              = err_q;
    assign flush            = flush_q;

endmodule

// File: tb/tb_router_nport_core.sv
module tb_router_nport_core;

    localparam int NP = 3;
    localparam int DP = 8;
    localparam int TO = 30;

    logic            clk1 = 1'b0;
    logic            reset;
    logic            packet_valid_i;
    logic [7:0]      packet_in;
    logic [NP-1:0]   read_enable;
    logic [8*NP-1:0] packet_out;
    logic [NP-1:0]   packet_valid_o;
    logic            busy;
    logic            stop_packet_send;
    logic            err;
    logic [NP-1:0]   flush;

    router_nport_core #(
        .NUM_PORTS (NP),
        .DEPTH     (DP),
        .TIMEOUT   (TO)
    ) dut (
        .clk1             (clk1),
        .reset            (reset),
        .packet_valid_i   (packet_valid_i),
        .packet_in        (packet_in),
        .read_enable      (read_enable),
        .packet_out       (packet_out),
        .packet_valid_o   (packet_valid_o),
        .busy             (busy),
        .stop_packet_send (stop_packet_send),
        .err              (err),
        .flush            (flush)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    int flush_cnt [NP];
    logic [7:0] exp_q [NP][$];

    // Count high cycles of the pulse outputs (value held during the cycle before this edge).
    always @(posedge clk1) begin
        if (err === 1'b1) err_cnt <= err_cnt + 1;
        for (int k = 0; k < NP; k++) begin
            if (flush[k] === 1'b1) flush_cnt[k] <= flush_cnt[k] + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present one byte, hold it while busy, return on the negedge after it transfers.
    task automatic send(input logic [7:0] b, input int port, input bit last, output int waits);
        packet_valid_i = 1'b1;
        packet_in      = b;
        waits          = 0;
        #1;
        while (busy && waits < 200) begin
            @(negedge clk1);
            #1;
            waits++;
        end
        if (waits >= 200) chk("send_busy_bound", 32'(busy), 0);
        if (port >= 0) exp_q[port].push_back(b);
        @(negedge clk1);
        if (last) packet_valid_i = 1'b0;
    endtask

    // Pop one byte from port k and compare against the scoreboard.
    task automatic rd(input int k);
        logic [7:0] e;
        chk($sformatf("rd_valid_p%0d", k), 32'(packet_valid_o[k]), 1);
        e = (exp_q[k].size() > 0) ? exp_q[k].pop_front() : 8'h00;
        read_enable[k] = 1'b1;
        @(negedge clk1);
        read_enable[k] = 1'b0;
        chk($sformatf("rd_data_p%0d", k), 32'(packet_out[8*k +: 8]), 32'(e));
    endtask

    initial begin
        int w;
        int wsum;
        int base;
        int n;

        reset          = 1'b1;
        packet_valid_i = 1'b0;
        packet_in      = 8'h00;
        read_enable    = '0;
        repeat (3) @(negedge clk1);
        reset = 1'b0;
        #1;
        chk("rst_pvo",   32'(packet_valid_o), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_stop",  32'(stop_packet_send), 0);
        chk("rst_err",   32'(err), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_pout",  32'(packet_out), 0);
        @(negedge clk1);

        // T1: len3 dest1, parity 0D^A1^B2^C3 = DD.
        send(8'h0D, 1, 0, w);
        send(8'hA1, 1, 0, w);
        send(8'hB2, 1, 0, w);
        send(8'hC3, 1, 0, w);
        send(8'hDD, 1, 1, w);
        repeat (2) @(negedge clk1);
        chk("t1_err_cnt", 32'(err_cnt), 0);
        chk("t1_pvo", 32'(packet_valid_o), 2);
        repeat (5) rd(1);
        chk("t1_pvo_after", 32'(packet_valid_o), 0);

        // T2: same packet, wrong parity.
        send(8'h0D, 1, 0, w);
        send(8'hA1, 1, 0, w);
        send(8'hB2, 1, 0, w);
        send(8'hC3, 1, 0, w);
        send(8'h00, 1, 1, w);
        #1;
        chk("t2_busy_in_check", 32'(busy), 1);
        @(negedge clk1);
        chk("t2_err_high", 32'(err), 1);
        @(negedge clk1);
        chk("t2_err_low", 32'(err), 0);
        chk("t2_err_cnt", 32'(err_cnt), 1);
        chk("t2_pvo", 32'(packet_valid_o), 2);
        repeat (5) rd(1);

        // T3: dest3 is illegal, followed by 4 bytes that must be discarded.
        base = err_cnt;
        wsum = 0;
        send(8'h07, -1, 0, w); wsum += w;
        chk("t3_err_pulse", 32'(err), 1);
        send(8'h11, -1, 0, w); wsum += w;
        send(8'h22, -1, 0, w); wsum += w;
        send(8'h33, -1, 0, w); wsum += w;
        send(8'h44, -1, 1, w); wsum += w;
        repeat (2) @(negedge clk1);
        chk("t3_no_busy", 32'(wsum), 0);
        chk("t3_err_cnt", 32'(err_cnt - base), 1);
        chk("t3_pvo", 32'(packet_valid_o), 0);
        // len==0 header to a legal port is dropped too.
        send(8'h01, -1, 1, w);
        repeat (2) @(negedge clk1);
        chk("t3_len0_err", 32'(err_cnt - base), 2);
        chk("t3_len0_pvo", 32'(packet_valid_o), 0);

        // Truncation: len2 dest1, valid falls after one payload byte.
        base = err_cnt;
        send(8'h09, 1, 0, w);
        send(8'h10, 1, 1, w);
        @(negedge clk1);
        chk("trunc_err", 32'(err), 1);
        @(negedge clk1);
        chk("trunc_err_cnt", 32'(err_cnt - base), 1);
        rd(1);
        rd(1);
        read_enable[1] = 1'b1;
        @(negedge clk1);
        read_enable[1] = 1'b0;
        chk("empty_read_hold", 32'(packet_out[15:8]), 32'h10);
        chk("empty_read_pvo", 32'(packet_valid_o), 0);

        // T4: len8 to port 0 (10 bytes) into an 8-deep FIFO with no reads.
        base = err_cnt;
        wsum = 0;
        send(8'h20, 0, 0, w); wsum += w;
        for (int i = 1; i <= 7; i++) begin
            send(8'(i), 0, 0, w);
            wsum += w;
        end
        chk("t4_no_stall_fill", 32'(wsum), 0);
        packet_valid_i = 1'b1;
        packet_in      = 8'h08;
        #1;
        chk("t4_busy_full", 32'(busy), 1);
        chk("t4_stop", 32'(stop_packet_send), 1);
        @(negedge clk1);
        #1;
        chk("t4_busy_hold", 32'(busy), 1);
        rd(0);
        send(8'h08, 0, 0, w);
        rd(0);
        send(8'h28, 0, 1, w);
        repeat (8) rd(0);
        chk("t4_err_cnt", 32'(err_cnt - base), 0);
        chk("t4_stop_clear", 32'(stop_packet_send), 0);
        chk("t4_pvo", 32'(packet_valid_o), 0);

        // T5: leave a len1 packet unread at port 2; header write edge starts the idle count.
        send(8'h06, 2, 0, w);
        send(8'h5A, 2, 0, w);
        send(8'h5C, 2, 1, w);
        chk("t5_pvo_before", 32'(packet_valid_o), 4);
        n = 0;
        while (!flush[2] && n < 100) begin
            @(negedge clk1);
            n++;
        end
        // Counter advances on the 30 edges after the header edge; two of them are already past.
        chk("t5_flush_cycle", 32'(n), 28);
        chk("t5_pvo_after", 32'(packet_valid_o), 0);
        @(negedge clk1);
        chk("t5_flush_pulse_end", 32'(flush), 0);
        chk("t5_flush_cnt2", 32'(flush_cnt[2]), 1);
        chk("t5_flush_cnt_other", 32'(flush_cnt[0] + flush_cnt[1]), 0);
        exp_q[2].delete();

        // T6: reset in the middle of LOAD, then a clean packet to port 0.
        base = err_cnt;
        send(8'h0D, 1, 0, w);
        send(8'hA1, 1, 0, w);
        reset          = 1'b1;
        packet_valid_i = 1'b0;
        @(negedge clk1);
        reset = 1'b0;
        exp_q[1].delete();
        #1;
        chk("t6_pvo_reset", 32'(packet_valid_o), 0);
        chk("t6_busy_reset", 32'(busy), 0);
        send(8'h04, 0, 0, w);
        send(8'h77, 0, 0, w);
        send(8'h73, 0, 1, w);
        repeat (2) @(negedge clk1);
        chk("t6_err_cnt", 32'(err_cnt - base), 0);
        chk("t6_pvo", 32'(packet_valid_o), 1);
        repeat (3) rd(0);
        chk("t6_pvo_after", 32'(packet_valid_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
